// File: rtl/instr_sequencer_pkg.sv
// Shared state encodings and field-width defaults for the instruction sequencer.
package instr_sequencer_pkg;
  localparam logic [2:0] ST_FETCH = 3'b000;
  localparam logic [2:0] ST_EXEC1 = 3'b001;
  localparam logic [2:0] ST_EXEC2 = 3'b010;

  localparam int OP_W_DEF  = 4;
  localparam int CNT_W_DEF = 4;

  function automatic logic is_illegal_state(input logic [2:0] s);
    return (s > ST_EXEC2);
  endfunction
endpackage

// File: rtl/instr_sequencer_loop_counter.sv
// Repeat counter: loads on fetch, counts down once per EXEC1, saturates at zero.
module instr_sequencer_loop_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/instr_sequencer.sv
// Current-state and instruction registers, plus the Extra/Loop qualifiers
// fed back to the external next-state logic.
//   state | meaning
//   000   | FETCH: wait for mem_ready, latch instruction
//   001   | EXEC1: execute, repeated while the count is non-zero
//   010   | EXEC2: optional second execute cycle
//   3..7  | illegal, flagged in state_err
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int                     DATA_W     = 16,
  parameter int                     OP_W       = OP_W_DEF,
  parameter int                     CNT_W      = CNT_W_DEF,
  parameter logic [(1<<OP_W)-1:0]   EXTRA_MASK = 16'h00F0,
  parameter logic [(1<<OP_W)-1:0]   LOOP_MASK  = 16'h0C00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ns,
  input  logic              fetch,
  input  logic              exec1,
  input  logic              exec2,
  input  logic              stall,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              mem_ready,
  output logic [2:0]        cs,
  output logic              Extra,
  output logic              Loop,
  output logic [DATA_W-1:0] ir,
  output logic              pc_inc,
  output logic              instr_done,
  output logic              state_err
);
  logic [2:0]        r_cs;
  logic [DATA_W-1:0] r_ir;
  logic              r_state_err;

  logic [OP_W-1:0]   w_op_in;
  logic [OP_W-1:0]   w_op_ir;
  logic              w_is_fetch;
  logic              w_is_exec1;
  logic              w_load;
  logic              w_dec;
  logic [CNT_W-1:0]  w_load_val;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_cnt_zero;

  assign w_op_in    = instr_in[DATA_W-1 -: OP_W];
  assign w_op_ir    = r_ir[DATA_W-1 -: OP_W];
  assign w_is_fetch = (r_cs == ST_FETCH);
  assign w_is_exec1 = (r_cs == ST_EXEC1);
  assign w_load     = ~stall & w_is_fetch & mem_ready;
  assign w_dec      = ~stall & w_is_exec1;
  // Non-looping opcodes clear the count so their low bits are ignored.
  assign w_load_val = LOOP_MASK[w_op_in] ? instr_in[CNT_W-1:0] : '0;

  instr_sequencer_loop_counter #(
    .CNT_W (CNT_W)
  ) u_loop_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs        <= ST_FETCH;
      r_ir        <= '0;
      r_state_err <= 1'b0;
    end else if (!stall) begin
      if (!(w_is_fetch && !mem_ready)) begin
        r_cs <= ns;
      end
      if (w_load) begin
        r_ir <= instr_in;
      end
      if (is_illegal_state(r_cs)) begin
        r_state_err <= 1'b1;
      end
    end
  end

  assign cs         = r_cs;
  assign ir         = r_ir;
  assign state_err  = r_state_err;
  assign Extra      = EXTRA_MASK[w_op_ir];
  assign Loop       = exec1 & ~w_cnt_zero;
  assign pc_inc     = fetch & mem_ready & ~stall;
  assign instr_done = ~stall & ((exec1 & w_cnt_zero & ~Extra) | exec2);
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer; models the external next-state decoder.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ns;
  logic        fetch, exec1, exec2;
  logic        stall;
  logic [15:0] instr_in;
  logic        mem_ready;
  logic [2:0]  cs;
  logic        Extra, Loop, pc_inc, instr_done, state_err;
  logic [15:0] ir;

  logic        force_en;
  logic [2:0]  force_ns;
  logic [7:0]  w_obs;

  int checks   = 0;
  int failures = 0;

  instr_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ns         (ns),
    .fetch      (fetch),
    .exec1      (exec1),
    .exec2      (exec2),
    .stall      (stall),
    .instr_in   (instr_in),
    .mem_ready  (mem_ready),
    .cs         (cs),
    .Extra      (Extra),
    .Loop       (Loop),
    .ir         (ir),
    .pc_inc     (pc_inc),
    .instr_done (instr_done),
    .state_err  (state_err)
  );

  always #5 clk = ~clk;

  // External next-state logic and strobe decode
  always_comb begin
    fetch = (cs == 3'b000);
    exec1 = (cs == 3'b001);
    exec2 = (cs == 3'b010);
    case (cs)
      3'b000:  ns = 3'b001;
      3'b001:  ns = Loop ? 3'b001 : (Extra ? 3'b010 : 3'b000);
      default: ns = 3'b000;
    endcase
    if (force_en) ns = force_ns;
  end

  // {cs, Extra, Loop, pc_inc, instr_done, state_err}
  assign w_obs = {cs, Extra, Loop, pc_inc, instr_done, state_err};

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; mem_ready = 1'b0; instr_in = '0;
    force_en = 1'b0; force_ns = '0;
    #1;
    checks++;
    if (w_obs !== 8'b000_00000 || ir !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state obs=%b ir=%h exp=00000000 ir=0000", w_obs, ir);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (w_obs !== 8'b000_00000) begin
      failures++;
      $display("FAIL reset_release obs=%b exp=00000000", w_obs);
    end
  endtask

  task automatic test_plain();
    logic [7:0] exp [3] = '{8'b000_00100, 8'b001_00010, 8'b000_00000};
    logic       mr  [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = mr[i]; instr_in = 16'h1000;
      #1;
      checks++;
      if (w_obs !== exp[i]) begin
        failures++;
        $display("FAIL plain cyc%0d obs=%b exp=%b", i, w_obs, exp[i]);
      end
    end
    checks++;
    if (ir !== 16'h1000) begin
      failures++;
      $display("FAIL plain_ir got=%h exp=1000", ir);
    end
  endtask

  task automatic test_extra();
    logic [7:0] exp [4] = '{8'b000_00100, 8'b001_10000, 8'b010_10010, 8'b000_10000};
    logic       mr  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = mr[i]; instr_in = 16'h5000;
      #1;
      checks++;
      if (w_obs !== exp[i]) begin
        failures++;
        $display("FAIL extra cyc%0d obs=%b exp=%b", i, w_obs, exp[i]);
      end
    end
  endtask

  task automatic test_loop();
    logic [7:0] exp3 [6] = '{8'b000_10100, 8'b001_01000, 8'b001_01000,
                             8'b001_01000, 8'b001_00010, 8'b000_00000};
    logic [7:0] exp0 [3] = '{8'b000_00100, 8'b001_00010, 8'b000_00000};
    logic [15:0] ins [2] = '{16'hA000, 16'h1007};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); mem_ready = (i == 0); instr_in = 16'hA003;
      #1;
      checks++;
      if (w_obs !== exp3[i]) begin
        failures++;
        $display("FAIL loop3 cyc%0d obs=%b exp=%b", i, w_obs, exp3[i]);
      end
    end
    // count 0 on a looping opcode, and count bits ignored on a plain opcode
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); mem_ready = (i == 0); instr_in = ins[k];
        #1;
        checks++;
        if (w_obs !== exp0[i]) begin
          failures++;
          $display("FAIL loop_single ins=%h cyc%0d obs=%b exp=%b", ins[k], i, w_obs, exp0[i]);
        end
      end
    end
  endtask

  task automatic test_wait_stall();
    logic [7:0]  exp [8] = '{8'b000_00000, 8'b000_00000, 8'b000_00100, 8'b001_01000,
                             8'b001_01000, 8'b001_01000, 8'b001_00010, 8'b000_00000};
    logic [15:0] ins [8] = '{16'hFFFF, 16'hFFFF, 16'hB002, 16'h0000,
                             16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic        mr  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        st  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); mem_ready = mr[i]; instr_in = ins[i]; stall = st[i];
      #1;
      done_cnt += int'(instr_done);
      checks++;
      if (w_obs !== exp[i]) begin
        failures++;
        $display("FAIL wait_stall cyc%0d obs=%b exp=%b", i, w_obs, exp[i]);
      end
      if (i == 1) begin
        checks++;
        if (ir !== 16'h1007) begin
          failures++;
          $display("FAIL wait_ir_hold got=%h exp=1007", ir);
        end
      end
    end
    stall = 1'b0;
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL wait_done_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_state_err();
    logic [7:0] exp [4] = '{8'b000_00100, 8'b101_00000, 8'b000_00001, 8'b000_00001};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = (i == 0); instr_in = 16'h1000;
      force_en = (i == 0); force_ns = 3'b101;
      #1;
      checks++;
      if (w_obs !== exp[i]) begin
        failures++;
        $display("FAIL state_err cyc%0d obs=%b exp=%b", i, w_obs, exp[i]);
      end
    end
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [2] = '{8'b000_00101, 8'b001_01001};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mem_ready = (i == 0); instr_in = 16'hA003;
      #1;
      checks++;
      if (w_obs !== exp[i]) begin
        failures++;
        $display("FAIL rst_mid_pre cyc%0d obs=%b exp=%b", i, w_obs, exp[i]);
      end
    end
    #1; rst_n = 1'b0;
    #1;
    checks++;
    if (w_obs !== 8'b000_00000 || ir !== 16'h0000) begin
      failures++;
      $display("FAIL rst_mid_async obs=%b ir=%h exp=00000000 ir=0000", w_obs, ir);
    end
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; instr_in = 16'h1000;
    #1;
    checks++;
    if (w_obs !== 8'b000_00100) begin
      failures++;
      $display("FAIL rst_mid_fetch obs=%b exp=00000100", w_obs);
    end
    @(negedge clk); mem_ready = 1'b0;
    #1;
    checks++;
    if (w_obs !== 8'b001_00010) begin
      failures++;
      $display("FAIL rst_mid_exec obs=%b exp=00100010", w_obs);
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_extra();
    test_loop();
    test_wait_stall();
    test_state_err();
    test_reset_mid();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
